// File: rtl/seq_sub64.sv
// Multi-cycle subtractor: Diff = A - B - Bin, one CHUNK-bit slice per clock
// through a registered borrow chain, with valid/ready handshakes on both sides.
module seq_sub64 #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             brw_q;
    logic             borrow_q, ovf_q, zero_q;

    logic [CHUNK+1:0] slice;
    logic [CHUNK-1:0] slice_r;
    logic             slice_bo, slice_bmsb;
    logic             last;
    logic [WIDTH-1:0] diff_next;

    // Returns {borrow out of slice, borrow into slice MSB, CHUNK-bit difference}.
    function automatic logic [CHUNK+1:0] sub_slice(input logic [CHUNK-1:0] x,
                                                   input logic [CHUNK-1:0] y,
                                                   input logic             bi);
        logic [CHUNK:0]   full;
        logic [CHUNK-1:0] low;
        full = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bi};
        low  = {1'b0, x[CHUNK-2:0]} - {1'b0, y[CHUNK-2:0]} - {{(CHUNK-1){1'b0}}, bi};
        return {full[CHUNK], low[CHUNK-1], full[CHUNK-1:0]};
    endfunction

    assign slice      = sub_slice(a_q[CHUNK-1:0], b_q[CHUNK-1:0], brw_q);
    assign slice_bo   = slice[CHUNK+1];
    assign slice_bmsb = slice[CHUNK];
    assign slice_r    = slice[CHUNK-1:0];
    assign last       = (cnt_q == CW'(NSLICE - 1));
    assign diff_next  = {slice_r, diff_q[WIDTH-1:CHUNK]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Slices enter diff_q from the top so the first (LSB) slice lands at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        brw_q <= bin;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    a_q    <= a_q >> CHUNK;
                    b_q    <= b_q >> CHUNK;
                    diff_q <= diff_next;
                    brw_q  <= slice_bo;
                    if (last) begin
                        cnt_q    <= '0;
                        borrow_q <= slice_bo;
                        ovf_q    <= slice_bo ^ slice_bmsb;
                        zero_q   <= (diff_next == '0);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_seq_sub64.sv
// Directed and random checks of seq_sub64 against hand values and a reference model.
module tb_seq_sub64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a, b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        borrow, overflow, zero;

    int n_chk = 0;
    int n_err = 0;

    seq_sub64 #(.WIDTH(64), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [63:0] ed, input logic eb,
                                input logic eo, input logic ez);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_borrow"}, 64'(borrow), 64'(eb));
        chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
        chk({tag, "_zero"}, 64'(zero), 64'(ez));
    endtask

    // One complete transaction; stall = cycles spent in DONE with out_ready low.
    task automatic do_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                         input logic tbin, input int stall, input logic chk_lat,
                         input logic [63:0] ed, input logic eb, input logic eo, input logic ez);
        int lat;
        chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'(1));
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_v;
        bin       = tbin;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb_v;
        lat      = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(1));
        if (chk_lat) chk({tag, "_latency"}, 64'(lat), 64'(8));
        check_result(tag, ed, eb, eo, ez);
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                in_valid = (i == 1);
                a        = 64'h0123_4567_89AB_CDEF;
                b        = 64'h1;
                tick();
                chk({tag, "_stall_valid"}, 64'(out_valid), 64'(1));
                chk({tag, "_stall_in_ready"}, 64'(in_ready), 64'(0));
                check_result({tag, "_stall"}, ed, eb, eo, ez);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        chk({tag, "_back_idle"}, 64'(in_ready), 64'(1));
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'(0));
    endtask

    logic [63:0] ra, rb, md;
    logic        rbin, mb, mo, mz;
    logic [64:0] ext;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_diff", diff, 64'h0);
        chk("rst_flags", {61'b0, borrow, overflow, zero}, 64'h0);
        #2 rst_n = 1'b1;
        tick();

        do_op("sub_5_3", 64'h5, 64'h3, 1'b0, 0, 1'b1, 64'h2, 1'b0, 1'b0, 1'b0);
        do_op("ripple", 64'h0, 64'h1, 1'b0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        do_op("ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 0, 1'b1,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
        do_op("zero_bin", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEEF, 1'b1, 0, 1'b1,
              64'h0, 1'b0, 1'b0, 1'b1);
        do_op("stall", 64'd100, 64'd58, 1'b0, 5, 1'b1, 64'd42, 1'b0, 1'b0, 1'b0);
        do_op("after_stall", 64'd10, 64'd4, 1'b0, 0, 1'b1, 64'd6, 1'b0, 1'b0, 1'b0);

        // Reset asynchronously while slice 4 is in flight.
        in_valid = 1'b1;
        a        = 64'hFFFF_FFFF_FFFF_FFFF;
        b        = 64'h0;
        bin      = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_diff", diff, 64'h0);
        #2 rst_n = 1'b1;
        tick();
        do_op("post_rst", 64'd7, 64'd7, 1'b0, 0, 1'b1, 64'h0, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            if (n % 10 == 0) rb = ra;
            rbin = 1'($urandom_range(0, 1));
            md   = ra - rb - 64'(rbin);
            mb   = ({1'b0, ra} < ({1'b0, rb} + 65'(rbin)));
            ext  = {ra[63], ra} - {rb[63], rb} - 65'(rbin);
            mo   = (ext[64] != ext[63]);
            mz   = (md == 64'h0);
            do_op("rand", ra, rb, rbin, int'($urandom_range(0, 3)), 1'b0, md, mb, mo, mz);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
